phase_accum_divider: RTL and testbench

Multi-channel phase-accumulator clock divider/tick generator. Each of CHANNELS independent WIDTH-bit accumulators adds a per-channel increment every enabled cycle. Each channel produces a square wave (accumulator MSB) and a one-cycle tick on wrap. Increments are reprogrammable at run time through a valid/ready port and apply only at the channel's next wrap, so output periods change glitch-free. Sits between the board clock and the slow-rate consumers (display scan, debouncers, timers).

---
 rtl/phase_accum_divider_if.sv | 13 +
 rtl/phase_accum_divider.sv | 101 ++++++++++
 tb/tb_phase_accum_divider.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/phase_accum_divider_if.sv
// Increment-update port: one request per valid/ready transfer, channel index plus new increment.
interface phase_accum_divider_if #(
  parameter int WIDTH = 32,
  parameter int CHW   = 2
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_chan;
  logic [WIDTH-1:0] cfg_inc;

  modport master (output cfg_valid, output cfg_chan, output cfg_inc, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_chan, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/phase_accum_divider.sv
// Multi-channel phase-accumulator divider: slowClk is the registered acc MSB (no extra latency), tick is registered on wrap.
// One increment update outstanding; cfg_ready drops while it waits for the target channel's next wrap.
module phase_accum_divider #(
  parameter int WIDTH         = 32,
  parameter int CHANNELS      = 4,
  parameter int FREQUENCY_IN  = 50000000,
  parameter int FREQUENCY_OUT = 1,
  parameter logic [WIDTH-1:0] DEFAULT_INC =
    WIDTH'((((64'd1 << WIDTH) * 64'(FREQUENCY_OUT)) - 64'd1) / 64'(FREQUENCY_IN) + 64'd1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  phase_accum_divider_if.slave cfg,
  output logic [CHANNELS-1:0] slowClk,
  output logic [CHANNELS-1:0] tick
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHW:0] NCH = (CHW+1)'(CHANNELS);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc [CHANNELS];
  logic [WIDTH-1:0] inc [CHANNELS];
  logic [WIDTH-1:0] sum [CHANNELS];
  logic [CHANNELS-1:0] carry;
  logic [CHW-1:0]   pend_chan;
  logic [WIDTH-1:0] pend_inc;
  logic             accept;
  logic             apply;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      {carry[c], sum[c]} = {1'b0, acc[c]} + {1'b0, inc[c]};
      slowClk[c]         = acc[c][WIDTH-1];
    end
  end

  assign cfg.cfg_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pending increment lands at the edge where the old one last matters:
  // the target's wrap, or immediately if the channel cannot advance.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.cfg_valid && ({1'b0, cfg.cfg_chan} < NCH)) begin
          accept    = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (sync || !enable[pend_chan] || (inc[pend_chan] == '0) || carry[pend_chan]) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        inc[c] <= DEFAULT_INC;
      end
      tick      <= '0;
      pend_chan <= '0;
      pend_inc  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync) begin
          acc[c]  <= '0;
          tick[c] <= 1'b0;
        end else if (enable[c]) begin
          acc[c]  <= sum[c];
          tick[c] <= carry[c];
        end else begin
          tick[c] <= 1'b0;
        end
      end
      if (accept) begin
        pend_chan <= cfg.cfg_chan;
        pend_inc  <= cfg.cfg_inc;
      end
      if (apply) inc[pend_chan] <= pend_inc;
    end
  end

endmodule

// File: tb/tb_phase_accum_divider.sv
// Directed walk through the update/wrap interactions, then randomized traffic, against an integer phase model.
module tb_phase_accum_divider;
  localparam int W   = 8;
  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int MOD = 256;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] enable;
  logic           sync;
  logic [NCH-1:0] slowClk;
  logic [NCH-1:0] tick;

  phase_accum_divider_if #(.WIDTH(W), .CHW(CHW)) cfg_if ();

  phase_accum_divider #(
    .WIDTH(W), .CHANNELS(NCH), .FREQUENCY_IN(50000000), .FREQUENCY_OUT(1),
    .DEFAULT_INC(8'd64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync),
    .cfg(cfg_if.slave), .slowClk(slowClk), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase as an integer in [0,256), increment as an integer, one optional pending update.
  int macc [NCH];
  int minc [NCH];
  bit mtick [NCH];
  bit mpend;
  int mpc;
  int mpinc;
  int tick_total;

  task automatic model_edge();
    bit ready_before;
    bit do_apply;
    int s;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        macc[c] = 0; minc[c] = 64; mtick[c] = 0;
      end
      mpend = 0;
    end else begin
      ready_before = !mpend;
      do_apply = mpend && (sync || !enable[mpc] || minc[mpc] == 0 || (macc[mpc] + minc[mpc] >= MOD));
      for (int c = 0; c < NCH; c++) begin
        if (sync) begin
          macc[c] = 0; mtick[c] = 0;
        end else if (enable[c]) begin
          s = macc[c] + minc[c];
          mtick[c] = (s >= MOD);
          macc[c] = s % MOD;
        end else begin
          mtick[c] = 0;
        end
      end
      if (do_apply) begin
        minc[mpc] = mpinc;
        mpend = 0;
      end
      if (ready_before && cfg_if.cfg_valid && int'(cfg_if.cfg_chan) < NCH) begin
        mpend = 1; mpc = int'(cfg_if.cfg_chan); mpinc = int'(cfg_if.cfg_inc);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NCH-1:0] exp_slow;
    logic [NCH-1:0] exp_tick;
    for (int c = 0; c < NCH; c++) begin
      exp_slow[c] = (macc[c] >= MOD / 2);
      exp_tick[c] = mtick[c];
    end
    checks++;
    assert (slowClk === exp_slow) else begin
      failures++;
      $error("FAIL %s slowClk observed=%b expected=%b t=%0t", tag, slowClk, exp_slow, $time);
    end
    checks++;
    assert (tick === exp_tick) else begin
      failures++;
      $error("FAIL %s tick observed=%b expected=%b t=%0t", tag, tick, exp_tick, $time);
    end
    checks++;
    assert (cfg_if.cfg_ready === !mpend) else begin
      failures++;
      $error("FAIL %s cfg_ready observed=%b expected=%b t=%0t", tag, cfg_if.cfg_ready, !mpend, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    for (int c = 0; c < NCH; c++) tick_total += int'(tick[c]);
  endtask

  task automatic send(input int chan, input int incv, input string tag);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = CHW'(chan);
    cfg_if.cfg_inc   = W'(incv);
    step(tag);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    int pick;
    reset = 1'b1; enable = '0; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_chan = '0; cfg_if.cfg_inc = '0;
    for (int c = 0; c < NCH; c++) begin macc[c] = 0; minc[c] = 0; mtick[c] = 0; end
    mpend = 0; mpc = 0; mpinc = 0;

    // 1: reset, then free-running at inc 64 -> one tick per channel every 4 cycles
    step("reset0");
    step("reset1");
    reset = 1'b0; enable = '1;
    tick_total = 0;
    for (int i = 0; i < 8; i++) step("count64");
    checks++;
    assert (tick_total === 2 * NCH) else begin
      failures++;
      $error("FAIL tickcount observed=%0d expected=%0d", tick_total, 2 * NCH);
    end

    // 2: retarget ch1 to 128 mid-period; takes effect at its next wrap
    step("pre_cfg1");
    send(1, 128, "cfg1_accept");
    for (int i = 0; i < 8; i++) step("cfg1_run");

    // 3: disabled channel takes the update on the next edge
    enable[0] = 1'b0;
    send(0, 32, "cfg0_dis");
    step("cfg0_dis_apply");
    step("cfg0_dis_idle");
    enable[0] = 1'b1;
    for (int i = 0; i < 18; i++) step("cfg0_32_run");

    // 4: sync with an update outstanding
    send(2, 32, "sync_cfg");
    step("sync_wait");
    sync = 1'b1;
    step("sync_edge");
    sync = 1'b0;
    for (int i = 0; i < 10; i++) step("sync_resume");

    // 5: freeze ch0, then unfreeze with 16
    send(0, 0, "inc0_accept");
    for (int i = 0; i < 300 && !cfg_if.cfg_ready; i++) step("inc0_wait");
    checks++;
    assert (cfg_if.cfg_ready === 1'b1) else begin
      failures++;
      $error("FAIL inc0_timeout observed=%b expected=1", cfg_if.cfg_ready);
    end
    for (int i = 0; i < 6; i++) step("frozen");
    send(0, 16, "inc16_accept");
    for (int i = 0; i < 36; i++) step("inc16_run");

    // 6: reset while pending, then out-of-range channel
    send(1, 32, "pend_before_reset");
    reset = 1'b1;
    step("reset_pending");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("after_reset");
    send(3, 8, "chan_oob");
    for (int i = 0; i < 8; i++) step("oob_run");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      sync   = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NCH; c++) enable[c] = ($urandom_range(0, 7) != 0);
      cfg_if.cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_if.cfg_chan  = CHW'($urandom_range(0, 3));
      pick = $urandom_range(0, 6);
      case (pick)
        0: cfg_if.cfg_inc = 8'd0;
        1: cfg_if.cfg_inc = 8'd16;
        2: cfg_if.cfg_inc = 8'd64;
        3: cfg_if.cfg_inc = 8'd128;
        4: cfg_if.cfg_inc = 8'd200;
        default: cfg_if.cfg_inc = W'($urandom_range(1, 255));
      endcase
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
